// File: rtl/sccb_responder.sv
// SCCB/I2C-compatible responder: decodes ID/sub-address/data phases, drives ACK and read data.
// Optional SCCB_AUTOINC_EN: reg_addr advances after each written byte and each master-ACKed read byte.
module sccb_responder #(
  parameter logic [6:0] DEV_ID      = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, SUB, ACK_S,
    WDATA, ACK_W, RDATA, MACK, IGNORE
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_q, sda_q;
  logic [2:0]             bit_cnt_q;
  logic                   done_q, rw_q, mack_q, oe_q;
  logic [7:0]             shift_q, tx_q;
  logic [7:0]             addr_q, wdata_q;
  logic                   we_q, busy_q;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall;
  logic start_det, stop_det;
  logic rx_st;
  logic [7:0] rx_byte;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign rx_st     = (state_q == ADDR) || (state_q == SUB) ||
                     (state_q == WDATA);
  assign rx_byte   = {shift_q[6:0], sda_s};

  // Open-drain: only ever pull low; async reset clears oe_q at once.
  assign sda       = oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      done_q    <= 1'b0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b1;
      oe_q      <= 1'b0;
      shift_q   <= 8'h00;
      tx_q      <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
`ifdef SCCB_AUTOINC_EN
      if (we_q) addr_q <= addr_q + 8'd1;
`endif
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= 3'd0;
        done_q    <= 1'b0;
        oe_q      <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_det) begin
        state_q <= IDLE;
        done_q  <= 1'b0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        if (scl_rise && rx_st) begin
          shift_q   <= rx_byte;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) done_q <= 1'b1;
        end
        unique case (state_q)
          ADDR: begin
            if (scl_fall && done_q) begin
              done_q <= 1'b0;
              if (shift_q[7:1] == DEV_ID) begin
                state_q <= ACK_A;
                oe_q    <= 1'b1;
                rw_q    <= shift_q[0];
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ACK_A: begin
            if (scl_fall) begin
              bit_cnt_q <= 3'd0;
              if (rw_q) begin
                tx_q    <= reg_rdata;
                oe_q    <= ~reg_rdata[7];
                state_q <= RDATA;
              end else begin
                oe_q    <= 1'b0;
                state_q <= SUB;
              end
            end
          end
          SUB: begin
            if (scl_rise && bit_cnt_q == 3'd7) addr_q <= rx_byte;
            if (scl_fall && done_q) begin
              done_q  <= 1'b0;
              oe_q    <= 1'b1;
              state_q <= ACK_S;
            end
          end
          WDATA: begin
            if (scl_rise && bit_cnt_q == 3'd7) begin
              wdata_q <= rx_byte;
              we_q    <= 1'b1;
            end
            if (scl_fall && done_q) begin
              done_q  <= 1'b0;
              oe_q    <= 1'b1;
              state_q <= ACK_W;
            end
          end
          ACK_S, ACK_W: begin
            if (scl_fall) begin
              oe_q    <= 1'b0;
              state_q <= WDATA;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd7) begin
                oe_q      <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= MACK;
              end else begin
                tx_q      <= {tx_q[6:0], 1'b0};
                oe_q      <= ~tx_q[6];
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          MACK: begin
            if (scl_rise) begin
              mack_q <= sda_s;
              done_q <= 1'b1;
`ifdef SCCB_AUTOINC_EN
              // Advance before the reload fall so reg_rdata tracks the new address.
              if (!sda_s) addr_q <= addr_q + 8'd1;
`endif
            end
            if (scl_fall && done_q) begin
              done_q <= 1'b0;
              if (!mack_q) begin
                tx_q    <= reg_rdata;
                oe_q    <= ~reg_rdata[7];
                state_q <= RDATA;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-level bus master plus transaction-level register model.
// Honours SCCB_AUTOINC_EN when the same macro is defined for the DUT.
module tb_sccb_responder;

`ifdef SCCB_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy;
  logic [7:0] mem [256];

  pullup (sda);
  assign sda = sda_m ? 1'bz : 1'b0;
  assign reg_rdata = mem[reg_addr];

  always #5 clk = ~clk;

  sccb_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl_m),
    .sda      (sda),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        expq[$];
  int         checks = 0;
  int         errors = 0;
  int         we_cnt = 0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] last_wa = 8'h00, last_wd = 8'h00, prev_wa = 8'h00;
  logic       we_prev = 1'b0;
  logic [7:0] wb [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every reg_we pulse must match the next write the model predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) begin
        wr_t w;
        checks++;
        we_cnt++;
        prev_wa = last_wa;
        last_wa = reg_addr;
        last_wd = reg_wdata;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_we: got addr %0h data %0h expected none",
                   reg_addr, reg_wdata);
        end else begin
          w = expq.pop_front();
          if (reg_addr !== w.a || reg_wdata !== w.d) begin
            errors++;
            $display("FAIL we_value: got %0h/%0h expected %0h/%0h",
                     reg_addr, reg_wdata, w.a, w.d);
          end
        end
        if (we_prev) begin
          errors++;
          $display("FAIL we_width: got 2+ clk expected 1 clk");
        end
      end
      we_prev = reg_we;
    end else begin
      we_prev = 1'b0;
    end
  end

  task automatic wq();
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
    wq();
  endtask

  task automatic bit_io(input logic b, output logic r);
    sda_m = b; wq();
    scl_m = 1'b1; wq();
    r = sda; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ack,
                           input string nm);
    logic r;
    logic [7:0] rb;
    rb = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bit_io(v[i], r);
      rb = {rb[6:0], r};
    end
    chk({nm, "_echo"}, rb, v);
    bit_io(1'b1, r);
    chk({nm, "_ack"}, r, ack ? 1'b0 : 1'b1);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v);
    logic r;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, r);
      v = {v[6:0], r};
    end
    bit_io(mack ? 1'b0 : 1'b1, r);
    if (!mack) chk("nack_released", r, 1'b1);
  endtask

  task automatic do_write(input int n, input int part);
    logic match;
    logic r;
    match = (wb[0][7:1] == 7'h21) && !wb[0][0];
    bus_start();
    chk("busy_after_start", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (match && i >= 2) expq.push_back('{m_addr, wb[i]});
      send_byte(wb[i], match, $sformatf("wr_b%0d", i));
      if (match && i == 1) m_addr = wb[1];
      if (match && i >= 2 && AUTOINC) m_addr = m_addr + 8'd1;
    end
    for (int k = 0; k < part; k++) bit_io(wb[n][7-k], r);
    bus_stop();
    chk("busy_after_stop", busy, 1'b0);
    chk("addr_after_wr", reg_addr, m_addr);
  endtask

  task automatic do_read(input int n, output logic [7:0] first);
    logic [7:0] v, e;
    bus_start();
    send_byte(8'h43, 1'b1, "rd_id");
    first = 8'h00;
    for (int j = 0; j < n; j++) begin
      e = mem[m_addr];
      recv_byte(j < n - 1, v);
      chk($sformatf("rd_data%0d", j), v, e);
      if (j == 0) first = v;
      if (j < n - 1 && AUTOINC) m_addr = m_addr + 8'd1;
    end
    bus_stop();
    chk("rd_busy_after_stop", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rv;
    logic r;
    int w0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h0A] = 8'h76;
    wq();
    rst_n = 1'b1;
    wq();
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_we", reg_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", sda, 1'b1);

    // Single register write.
    w0 = we_cnt;
    wb[0] = 8'h42; wb[1] = 8'h12; wb[2] = 8'h80;
    do_write(3, 0);
    chk("t1_we_count", we_cnt - w0, 1);
    chk("t1_addr", last_wa, 8'h12);
    chk("t1_data", last_wd, 8'h80);

    // Set pointer, then read it back with NACK.
    w0 = we_cnt;
    wb[0] = 8'h42; wb[1] = 8'h0A;
    do_write(2, 0);
    do_read(1, rv);
    chk("t2_read", rv, 8'h76);
    chk("t2_no_we", we_cnt - w0, 0);

    // Foreign ID: responder must stay silent.
    w0 = we_cnt;
    wb[0] = 8'h60; wb[1] = 8'h33; wb[2] = 8'h44;
    do_write(3, 0);
    chk("t3_no_we", we_cnt - w0, 0);

    // STOP inside a data byte.
    w0 = we_cnt;
    wb[0] = 8'h42; wb[1] = 8'h1E; wb[2] = 8'hA5;
    do_write(2, 4);
    chk("t4_no_we", we_cnt - w0, 0);
    chk("t4_addr", reg_addr, 8'h1E);

    // Multi-byte write across the 0xFF boundary.
    w0 = we_cnt;
    wb[0] = 8'h42; wb[1] = 8'hFF; wb[2] = 8'h11; wb[3] = 8'h22;
    do_write(4, 0);
    chk("t5_we_count", we_cnt - w0, 2);
    chk("t5_addr1", prev_wa, 8'hFF);
    chk("t5_addr2", last_wa, AUTOINC ? 8'h00 : 8'hFF);
    chk("t5_data2", last_wd, 8'h22);

    // Multi-byte read with master ACK.
    wb[0] = 8'h42; wb[1] = 8'h30;
    do_write(2, 0);
    do_read(3, rv);
    chk("t6_first", rv, 8'h30 ^ 8'h5A);

    // Clocking with no START is ignored.
    scl_m = 1'b0; wq();
    send_byte(8'h42, 1'b0, "idle");
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    chk("idle_busy", busy, 1'b0);

    // Reset while the responder holds the ID ACK low.
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      rv = 8'h42;
      bit_io(rv[i], r);
    end
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    chk("pre_rst_ack", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_sda_release", sda, 1'b1);
    chk("rst2_addr", reg_addr, 8'h00);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_we", reg_we, 1'b0);
    chk("rst2_wdata", reg_wdata, 8'h00);
    m_addr = 8'h00;
    wq();
    scl_m = 1'b0; wq();
    rst_n = 1'b1; wq();
    w0 = we_cnt;
    wb[0] = 8'h42; wb[1] = 8'h05; wb[2] = 8'h33;
    do_write(3, 0);
    chk("t7_we_count", we_cnt - w0, 1);
    chk("t7_data", last_wd, 8'h33);

    wq();
    chk("pending_writes", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
